// File: rtl/workout_session_tracker_if.sv
// Per-second fitness sample channel: valid/ready plus HR, steps and stride payload.
interface workout_session_tracker_if #(
    parameter int HR_W     = 8,
    parameter int STEP_W   = 4,
    parameter int STRIDE_W = 8
) ();
    logic                sample_valid;
    logic                sample_ready;
    logic [HR_W-1:0]     hr_in;
    logic [STEP_W-1:0]   steps_in;
    logic [STRIDE_W-1:0] stride_in;

    modport master (output sample_valid, hr_in, steps_in, stride_in, input sample_ready);
    modport slave  (input sample_valid, hr_in, steps_in, stride_in, output sample_ready);
endinterface

// File: rtl/workout_session_tracker.sv
// Session tracker: saturating step/distance/time sums, window-averaged HR, debounced zone; 1-cycle latency.
// Backpressure: sample_ready high only while a session is ACTIVE; samples are refused in IDLE/DONE.
module workout_session_tracker #(
    parameter int HR_W     = 8,
    parameter int STEP_W   = 4,
    parameter int STRIDE_W = 8,
    parameter int DIST_W   = 32,
    parameter int STEPS_W  = 16,
    parameter int TIME_W   = 16,
    parameter int WIN_LOG2 = 3,
    parameter int WARN_TH  = 150,
    parameter int EMERG_TH = 180,
    parameter int PERSIST  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    workout_session_tracker_if.slave smp,
    output logic                 session_active,
    output logic [STEPS_W-1:0]   total_steps,
    output logic [DIST_W-1:0]    total_distance,
    output logic [TIME_W-1:0]    elapsed,
    output logic [HR_W-1:0]      max_hr,
    output logic [HR_W-1:0]      avg_hr,
    output logic                 avg_valid,
    output logic [1:0]           hr_zone,
    output logic                 alarm
);
    localparam int DEPTH  = 1 << WIN_LOG2;
    localparam int SUM_W  = HR_W + WIN_LOG2;
    localparam int PROD_W = STEP_W + STRIDE_W;
    localparam int CNT_W  = $clog2(PERSIST + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]          state;
    logic                accept;
    logic                clear;
    logic [HR_W-1:0]     win [DEPTH];
    logic [WIN_LOG2-1:0] wr_ptr;
    logic [WIN_LOG2:0]   fill;
    logic [SUM_W-1:0]    sum;
    logic [1:0]          cand;
    logic [CNT_W-1:0]    cnt;

    logic [STEPS_W:0]    steps_sum;
    logic [PROD_W-1:0]   prod;
    logic [DIST_W:0]     dist_sum;
    logic [HR_W-1:0]     evicted;
    logic [SUM_W-1:0]    new_sum;
    logic                win_full;
    logic                avg_valid_next;
    logic [1:0]          raw_zone;
    logic [CNT_W-1:0]    next_cnt;

    assign smp.sample_ready = (state == S_ACTIVE);
    assign session_active   = (state == S_ACTIVE);
    assign accept           = smp.sample_valid && (state == S_ACTIVE);
    assign clear            = start && (state != S_ACTIVE);

    always_comb begin
        steps_sum      = {1'b0, total_steps} + (STEPS_W+1)'(smp.steps_in);
        prod           = PROD_W'(smp.steps_in) * PROD_W'(smp.stride_in);
        dist_sum       = {1'b0, total_distance} + (DIST_W+1)'(prod);
        win_full       = (fill == (WIN_LOG2+1)'(DEPTH));
        evicted        = win_full ? win[wr_ptr] : '0;
        new_sum        = sum + SUM_W'(smp.hr_in) - SUM_W'(evicted);
        avg_valid_next = win_full || (fill == (WIN_LOG2+1)'(DEPTH - 1));
        raw_zone       = 2'd2;
        if (int'(smp.hr_in) <= WARN_TH)       raw_zone = 2'd0;
        else if (int'(smp.hr_in) <= EMERG_TH) raw_zone = 2'd1;
        next_cnt       = (raw_zone == cand) ? cnt + CNT_W'(1) : CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) state <= S_ACTIVE;
                S_ACTIVE:       if (stop)  state <= S_DONE;
                default:        state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        end else if (accept) begin
            win[wr_ptr] <= smp.hr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            total_steps    <= '0;
            total_distance <= '0;
            elapsed        <= '0;
            max_hr         <= '0;
            avg_hr         <= '0;
            avg_valid      <= 1'b0;
            hr_zone        <= 2'd0;
            alarm          <= 1'b0;
            wr_ptr         <= '0;
            fill           <= '0;
            sum            <= '0;
            cand           <= 2'd0;
            cnt            <= '0;
        end else if (accept) begin
            total_steps    <= steps_sum[STEPS_W] ? '1 : steps_sum[STEPS_W-1:0];
            total_distance <= dist_sum[DIST_W]   ? '1 : dist_sum[DIST_W-1:0];
            if (!(&elapsed)) elapsed <= elapsed + TIME_W'(1);
            if (smp.hr_in > max_hr) max_hr <= smp.hr_in;

            // Evicted entry only contributes once the ring has wrapped.
            wr_ptr    <= wr_ptr + WIN_LOG2'(1);
            sum       <= new_sum;
            if (!win_full) fill <= fill + (WIN_LOG2+1)'(1);
            avg_valid <= avg_valid_next;
            avg_hr    <= avg_valid_next ? HR_W'(new_sum >> WIN_LOG2) : '0;

            if (raw_zone == hr_zone) begin
                cnt <= '0;
            end else if (next_cnt == CNT_W'(PERSIST)) begin
                hr_zone <= raw_zone;
                alarm   <= (raw_zone == 2'd2);
                cand    <= raw_zone;
                cnt     <= '0;
            end else begin
                cand <= raw_zone;
                cnt  <= next_cnt;
            end
        end
    end
endmodule

// File: tb/tb_workout_session_tracker.sv
// Randomised and directed bench for workout_session_tracker against a queue-based session model.
module tb_workout_session_tracker;
    localparam int HR_W = 8, STEP_W = 4, STRIDE_W = 8, DIST_W = 12, STEPS_W = 8, TIME_W = 16;
    localparam int WIN = 8, WARN = 150, EMERG = 180, PERSIST = 3;
    localparam int STEPS_MAX = (1 << STEPS_W) - 1, DIST_MAX = (1 << DIST_W) - 1, TIME_MAX = (1 << TIME_W) - 1;
    localparam int M_IDLE = 0, M_ACTIVE = 1, M_DONE = 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic                session_active, avg_valid, alarm;
    logic [STEPS_W-1:0]  total_steps;
    logic [DIST_W-1:0]   total_distance;
    logic [TIME_W-1:0]   elapsed;
    logic [HR_W-1:0]     max_hr, avg_hr;
    logic [1:0]          hr_zone;

    always #5 clk = ~clk;

    workout_session_tracker_if #(.HR_W(HR_W), .STEP_W(STEP_W), .STRIDE_W(STRIDE_W)) smp ();

    workout_session_tracker #(
        .HR_W(HR_W), .STEP_W(STEP_W), .STRIDE_W(STRIDE_W), .DIST_W(DIST_W), .STEPS_W(STEPS_W),
        .TIME_W(TIME_W), .WIN_LOG2(3), .WARN_TH(WARN), .EMERG_TH(EMERG), .PERSIST(PERSIST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .smp(smp),
        .session_active(session_active), .total_steps(total_steps), .total_distance(total_distance),
        .elapsed(elapsed), .max_hr(max_hr), .avg_hr(avg_hr), .avg_valid(avg_valid),
        .hr_zone(hr_zone), .alarm(alarm)
    );

    int n_vec = 0, n_err = 0;

    // Reference model: session-level quantities, last-N HR queue, zone rules.
    int m_state = M_IDLE;
    int m_steps, m_dist, m_el, m_max, m_avg, m_zone, m_cand, m_cnt;
    bit m_avg_valid;
    int m_win[$];

    function void m_clear();
        m_steps = 0; m_dist = 0; m_el = 0; m_max = 0; m_avg = 0;
        m_zone = 0; m_cand = 0; m_cnt = 0; m_avg_valid = 0;
        m_win.delete();
    endfunction

    function void m_accept(int hr, int st, int sr);
        int raw;
        m_steps = (m_steps + st > STEPS_MAX) ? STEPS_MAX : m_steps + st;
        m_dist  = (m_dist + st * sr > DIST_MAX) ? DIST_MAX : m_dist + st * sr;
        m_el    = (m_el + 1 > TIME_MAX) ? TIME_MAX : m_el + 1;
        if (hr > m_max) m_max = hr;
        m_win.push_back(hr);
        if (m_win.size() > WIN) void'(m_win.pop_front());
        m_avg_valid = (m_win.size() == WIN);
        m_avg = m_avg_valid ? m_win.sum() / WIN : 0;
        raw = (hr <= WARN) ? 0 : (hr <= EMERG) ? 1 : 2;
        if (raw == m_zone) m_cnt = 0;
        else begin
            if (raw == m_cand) m_cnt++;
            else begin m_cand = raw; m_cnt = 1; end
            if (m_cnt == PERSIST) begin m_zone = m_cand; m_cnt = 0; end
        end
    endfunction

    task automatic drive(input bit st, input bit sp, input bit v, input int hr, input int steps, input int stride);
        start = st; stop = sp; smp.sample_valid = v;
        smp.hr_in = HR_W'(hr); smp.steps_in = STEP_W'(steps); smp.stride_in = STRIDE_W'(stride);
        if (v && m_state == M_ACTIVE) m_accept(hr, steps, stride);
        if (m_state != M_ACTIVE && st) begin m_clear(); m_state = M_ACTIVE; end
        else if (m_state == M_ACTIVE && sp) m_state = M_DONE;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; smp.sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; smp.sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; m_clear(); m_state = M_IDLE;
        for (int i = 0; i < 3; i++) begin
            smp.sample_valid = 1'b1; #1;
            n_vec++; if (smp.sample_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", smp.sample_ready); end
            drive(0, 0, 1, 120, 3, 50);
            n_vec++; if (elapsed !== '0) begin n_err++; $display("FAIL reset_elapsed got %0d want 0", elapsed); end
            n_vec++; if ({session_active, total_steps, total_distance, max_hr, avg_hr, avg_valid, hr_zone, alarm} !== '0) begin
                n_err++; $display("FAIL reset_outputs active=%b steps=%0d dist=%0d max=%0d avg=%0d", session_active, total_steps, total_distance, max_hr, avg_hr); end
        end
    endtask

    task automatic test_accumulate();
        drive(1, 0, 0, 0, 0, 0);
        n_vec++; if (session_active !== 1'b1) begin n_err++; $display("FAIL acc_active got %b want 1", session_active); end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 100, 2, 75);
            n_vec++; if (avg_valid !== (i >= 7)) begin n_err++; $display("FAIL acc_avg_valid accept %0d got %b", i + 1, avg_valid); end
            n_vec++; if (avg_hr !== HR_W'((i >= 7) ? 100 : 0)) begin n_err++; $display("FAIL acc_avg accept %0d got %0d", i + 1, avg_hr); end
        end
        n_vec++; if (total_steps !== STEPS_W'(20)) begin n_err++; $display("FAIL acc_steps got %0d want 20", total_steps); end
        n_vec++; if (total_distance !== DIST_W'(1500)) begin n_err++; $display("FAIL acc_dist got %0d want 1500", total_distance); end
        n_vec++; if (elapsed !== TIME_W'(10)) begin n_err++; $display("FAIL acc_elapsed got %0d want 10", elapsed); end
        n_vec++; if (max_hr !== HR_W'(100)) begin n_err++; $display("FAIL acc_max got %0d want 100", max_hr); end
    endtask

    task automatic test_window();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 1, 180, 2, 75);
            n_vec++; if (avg_hr !== HR_W'(100 + 10 * k)) begin n_err++; $display("FAIL win_avg k=%0d got %0d want %0d", k, avg_hr, 100 + 10 * k); end
        end
        drive(0, 0, 1, 100, 2, 75);
        n_vec++; if (avg_hr !== HR_W'(170)) begin n_err++; $display("FAIL win_avg_tail got %0d want 170", avg_hr); end
        n_vec++; if (max_hr !== HR_W'(180)) begin n_err++; $display("FAIL win_max got %0d want 180", max_hr); end
    endtask

    task automatic test_zone();
        int hrs[8]   = '{160, 160, 160, 200, 160, 200, 200, 200};
        int zones[8] = '{0, 0, 1, 1, 1, 1, 1, 2};
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, hrs[i], 0, 0);
            n_vec++; if (hr_zone !== 2'(zones[i])) begin n_err++; $display("FAIL zone step %0d got %0d want %0d", i, hr_zone, zones[i]); end
            n_vec++; if (alarm !== (zones[i] == 2)) begin n_err++; $display("FAIL zone_alarm step %0d got %b", i, alarm); end
        end
    endtask

    task automatic test_saturation();
        int exp_d[4] = '{3825, 4095, 4095, 4095};
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 100, 15, 255);
            n_vec++; if (total_distance !== DIST_W'(exp_d[i])) begin n_err++; $display("FAIL sat_dist accept %0d got %0d want %0d", i + 1, total_distance, exp_d[i]); end
        end
    endtask

    task automatic test_session_edges();
        logic [STEPS_W-1:0] s_steps;
        logic [DIST_W-1:0]  s_dist;
        logic [HR_W-1:0]    s_max;
        drive(0, 1, 1, 90, 1, 10);
        n_vec++; if (elapsed !== TIME_W'(5)) begin n_err++; $display("FAIL edge_stop_counted got %0d want 5", elapsed); end
        n_vec++; if (total_steps !== STEPS_W'(61)) begin n_err++; $display("FAIL edge_stop_steps got %0d want 61", total_steps); end
        n_vec++; if ({session_active, smp.sample_ready} !== 2'b00) begin n_err++; $display("FAIL edge_done got active=%b ready=%b want 0/0", session_active, smp.sample_ready); end
        s_steps = total_steps; s_dist = total_distance; s_max = max_hr;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 200, 15, 255);
            n_vec++; if (elapsed !== TIME_W'(5) || total_steps !== s_steps || total_distance !== s_dist || max_hr !== s_max) begin
                n_err++; $display("FAIL edge_frozen el=%0d steps=%0d dist=%0d max=%0d", elapsed, total_steps, total_distance, max_hr); end
        end
        drive(1, 0, 0, 0, 0, 0);
        n_vec++; if ({total_steps, total_distance, elapsed, max_hr, avg_valid, hr_zone} !== '0 || session_active !== 1'b1) begin
            n_err++; $display("FAIL edge_restart_clear active=%b steps=%0d el=%0d", session_active, total_steps, elapsed); end
        drive(1, 0, 1, 120, 3, 4);
        n_vec++; if (elapsed !== TIME_W'(1) || total_steps !== STEPS_W'(3)) begin n_err++; $display("FAIL edge_start_ignored el=%0d steps=%0d want 1/3", elapsed, total_steps); end
        drive(1, 1, 0, 0, 0, 0);
        n_vec++; if (session_active !== 1'b0) begin n_err++; $display("FAIL edge_stop_wins got %b want 0", session_active); end
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 130, 5, 6);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0; m_clear(); m_state = M_IDLE;
        n_vec++; if ({session_active, total_steps, total_distance, elapsed, max_hr, avg_hr, avg_valid, hr_zone, alarm} !== '0) begin
            n_err++; $display("FAIL edge_rst_mid active=%b steps=%0d el=%0d max=%0d", session_active, total_steps, elapsed, max_hr); end
    endtask

    task automatic test_random();
        int band = 0;
        for (int i = 0; i < 1500; i++) begin
            bit st, sp, v;
            int hr;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1; @(posedge clk); #1 rst = 1'b0; m_clear(); m_state = M_IDLE;
            end
            st = (m_state != M_ACTIVE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 30) == 0);
            sp = ($urandom_range(0, 60) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) band = $urandom_range(0, 2);
            case (band)
                0:       hr = $urandom_range(60, 150);
                1:       hr = $urandom_range(151, 180);
                default: hr = $urandom_range(181, 230);
            endcase
            drive(st, sp, v, hr, $urandom_range(0, 15), $urandom_range(0, 255));
            n_vec++; if (session_active !== (m_state == M_ACTIVE)) begin n_err++; $display("FAIL rnd_active cyc %0d got %b", i, session_active); end
            n_vec++; if (smp.sample_ready !== (m_state == M_ACTIVE)) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b", i, smp.sample_ready); end
            n_vec++; if (total_steps !== STEPS_W'(m_steps)) begin n_err++; $display("FAIL rnd_steps cyc %0d got %0d want %0d", i, total_steps, m_steps); end
            n_vec++; if (total_distance !== DIST_W'(m_dist)) begin n_err++; $display("FAIL rnd_dist cyc %0d got %0d want %0d", i, total_distance, m_dist); end
            n_vec++; if (elapsed !== TIME_W'(m_el)) begin n_err++; $display("FAIL rnd_elapsed cyc %0d got %0d want %0d", i, elapsed, m_el); end
            n_vec++; if (max_hr !== HR_W'(m_max)) begin n_err++; $display("FAIL rnd_max cyc %0d got %0d want %0d", i, max_hr, m_max); end
            n_vec++; if (avg_valid !== m_avg_valid) begin n_err++; $display("FAIL rnd_avg_valid cyc %0d got %b want %b", i, avg_valid, m_avg_valid); end
            n_vec++; if (avg_hr !== HR_W'(m_avg)) begin n_err++; $display("FAIL rnd_avg cyc %0d got %0d want %0d", i, avg_hr, m_avg); end
            n_vec++; if (hr_zone !== 2'(m_zone)) begin n_err++; $display("FAIL rnd_zone cyc %0d got %0d want %0d", i, hr_zone, m_zone); end
            n_vec++; if (alarm !== (m_zone == 2)) begin n_err++; $display("FAIL rnd_alarm cyc %0d got %b want %b", i, alarm, m_zone == 2); end
        end
    endtask

    initial begin
        smp.sample_valid = 1'b0; smp.hr_in = '0; smp.steps_in = '0; smp.stride_in = '0;
        test_reset();
        test_accumulate();
        test_window();
        test_zone();
        test_saturation();
        test_session_edges();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/workout_session_tracker.md
Name: workout_session_tracker

Overview:
Parametrised successor to the single-rate step calculator. Accepts per-second fitness samples (heart rate, steps, stride) over a valid/ready handshake inside a start/stop session FSM. It accumulates steps, distance and sample count with saturation, and keeps a sliding-window average HR over a circular buffer. It also produces a debounced HR zone and alarm; feeds the display/feedback logic downstream.

Parameters:
HR_W, 8, heart-rate width (bpm)
STEP_W, 4, steps-per-sample width
STRIDE_W, 8, stride length width (cm)
DIST_W, 32, total_distance width
STEPS_W, 16, total_steps width
TIME_W, 16, elapsed sample counter width
WIN_LOG2, 3, log2 of averaging window depth (window = 8 samples)
WARN_TH, 150, zone 0/1 boundary (hr <= WARN_TH is zone 0)
EMERG_TH, 180, zone 1/2 boundary (hr > EMERG_TH is zone 2)
PERSIST, 3, consecutive samples needed to change zone (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  pulse: clear accumulators, begin session
stop  in  1  pulse: end session, freeze outputs
sample_valid  in  1  sample present
sample_ready  out  1  block accepts sample
hr_in  in  HR_W  heart rate
steps_in  in  STEP_W  steps this sample
stride_in  in  STRIDE_W  stride length
session_active  out  1  FSM in ACTIVE
total_steps  out  STEPS_W  saturating step sum
total_distance  out  DIST_W  saturating sum of steps_in*stride_in
elapsed  out  TIME_W  accepted samples this session (saturating)
max_hr  out  HR_W  session maximum HR
avg_hr  out  HR_W  window average
avg_valid  out  1  window filled
hr_zone  out  2  debounced zone 00 safe/01 warn/10 emergency
alarm  out  1  hr_zone==10

Behaviour:
- One clock; reset is synchronous and active-high; ports named clk and rst. rst has priority over everything: all outputs 0, FSM IDLE, buffer contents, window sum, fill count and debounce counter cleared.
- FSM states IDLE, ACTIVE, DONE. IDLE/DONE + start -> ACTIVE; accumulators, buffer, max, avg, zone and debounce state cleared on that edge. ACTIVE + stop -> DONE; all outputs hold. start and stop in the same cycle while ACTIVE: stop wins. start while ACTIVE is ignored.
- sample_ready = 1 only in ACTIVE (combinational from state). Accept = sample_valid & sample_ready. A sample accepted in the same cycle as stop is counted. Samples are never accepted in IDLE/DONE.
- All outputs are registered and reflect an accepted sample on the edge that accepts it (1-cycle latency from handshake to output).
- Per accept:
  - total_steps += steps_in, saturating at all-ones.
  - total_distance += steps_in*stride_in (full-width product, zero-extended), saturating at all-ones.
  - elapsed += 1, saturating.
  - max_hr = max(max_hr, hr_in).
- Window: circular buffer of 2^WIN_LOG2 HR entries with a write pointer that wraps. Sum width is HR_W+WIN_LOG2. new_sum = sum + hr_in - evicted, where evicted is 0 until the buffer is full. avg_valid rises on the accept that fills the buffer and stays high until clear. While avg_valid=1, avg_hr = new_sum >> WIN_LOG2 (truncating); otherwise avg_hr = 0.
- Zone debounce: raw zone of hr_in is 0 if hr<=WARN_TH, 1 if hr<=EMERG_TH, else 2.
  - Raw == hr_zone: candidate counter cleared.
  - Raw differs and equals the candidate: counter += 1.
  - Raw differs and differs from the candidate: candidate = raw, counter = 1.
  - When the counter reaches PERSIST, hr_zone = candidate and the counter clears.
  - With PERSIST=1, the zone follows raw immediately.
  - The zone changes only on accepts.

Test Plan:
- Reset/idle: assert rst 2 cycles, then sample_valid=1 in IDLE -> sample_ready=0, all outputs 0, elapsed stays 0.
- Accumulate: start, then 10 accepts of steps=2, stride=75, hr=100 -> total_steps=20, total_distance=1500, elapsed=10, max_hr=100. avg_valid rises on the 8th accept with avg_hr=100.
- Sliding window: after eight hr=100 samples, feed eight hr=180 -> avg_hr after accepts 1..8 = 110,120,...,180. A ninth sample of 100 -> 170.
- Zone debounce (PERSIST=3): hr 160,160 -> zone 0. Third 160 -> zone 01. Then 200,160,200,200 -> zone stays 01. Then a further 200 -> zone 10, alarm=1.
- Saturation (DIST_W=12): steps=15, stride=255 per accept -> total_distance 3825, then 4095 (held) on the 2nd and later accepts.
- Session edges: stop with a sample in the same cycle -> sample counted, outputs frozen in DONE, sample_ready=0. Next start -> all cleared. rst mid-ACTIVE -> IDLE with outputs 0 next cycle.
